exec_ctrl: RTL
==============

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter DW, default 16, datapath width; SHALL equal the 16-bit ALU width.
REQ-002 Parameter RAW, default 3, register address width, giving 8 registers.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  16  fields: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] unused.
REQ-008 alu_a  output  16  ALU operand a.
REQ-009 alu_b  output  16  ALU operand b.
REQ-010 alu_aluc  output  3  ALU control code.
REQ-011 alu_y  input  16  ALU result.
REQ-012 alu_z  input  1  ALU equality flag.
REQ-013 wb_valid  output  1  one-cycle write-back strobe.
REQ-014 wb_addr  output  3  write-back register.
REQ-015 wb_data  output  16  write-back value.
REQ-016 cmp_eq  output  1  one-cycle pulse: compare result was equal.
REQ-017 dbg_addr  input  3  debug read address.
REQ-018 dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-019 SHALL hold an internal 8x16 register file; r0 SHALL read 0 and SHALL ignore writes.
REQ-020 FSM states SHALL be IDLE, FETCH, EXEC, WB; IDLE->FETCH on instr_valid&&instr_ready; FETCH->EXEC; EXEC->WB; WB->IDLE, unconditionally.
REQ-021 instr_ready SHALL be 1 only in IDLE; the handshake SHALL complete when instr_valid and instr_ready are both high on the same edge.
REQ-022 On accept, op/rd/rs/rt SHALL be latched; later changes on instr SHALL have no effect.
REQ-023 FETCH: SHALL register rs/rt register values into operand latches A and B.
REQ-024 EXEC: alu_a=A, alu_b=B, alu_aluc=op; alu_y and alu_z SHALL be registered at the end of EXEC.
REQ-025 alu_aluc SHALL equal op, 1:1: 000 add, 001 sub, 010 nand, 011 two's-complement negate, 100 arithmetic right shift, 101 logical right shift, 110 left shift, 111 compare.
REQ-026 For op 011, alu_b SHALL be driven 0.
REQ-027 Outside EXEC, alu_a, alu_b and alu_aluc SHALL be driven 0.
REQ-028 WB with op!=111: wb_valid=1, wb_addr=rd, wb_data=captured y; the register file SHALL be written on that edge (skipped if rd=0, but wb_valid still pulses).
REQ-029 WB with op=111: wb_valid=0, no register write; cmp_eq = captured z.
REQ-030 wb_valid and cmp_eq SHALL be high only in WB, for exactly one cycle.
REQ-031 Latency: accept on edge N; WB outputs SHALL be visible in cycle N+3; next accept SHALL be no earlier than edge N+4.
REQ-032 Arithmetic SHALL be modulo 2^16; the block SHALL add no flags beyond cmp_eq.
REQ-033 rd==rs or rd==rt SHALL read pre-write values; each instruction SHALL see all writes of prior instructions (serialised FSM, no hazards).
REQ-034 dbg_data SHALL reflect a write from the cycle after the WB edge.

Reset
REQ-035 On rst=1 at an edge: state=IDLE; all 8 registers=0; operand/result latches=0; wb_valid=0, wb_addr=0, wb_data=0, cmp_eq=0.
REQ-036 Reset during FETCH/EXEC/WB SHALL abort the instruction with no register write and no pulses.
REQ-037 instr_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Verification
REQ-038 Post-reset: dbg_data=0 for all 8 addresses; instr_ready=1; wb_valid=0.
REQ-039 Seed r1=5, r2=3 by pushing values through the ALU path, then add r3=r1+r2 -> wb_valid pulse at N+3 with wb_addr=3, wb_data=8; dbg r3=8.
REQ-040 Sub r4=r2-r1 (3-5) -> wb_data=0xFFFE; negate r5=-r1 -> 0xFFFB; op 100 with A=0x8000, B=1 -> 0xC000; op 101 -> 0x4000.
REQ-041 Compare r1,r1 -> cmp_eq=1 for one cycle with wb_valid=0; compare r1,r2 -> cmp_eq=0; register file unchanged.
REQ-042 Write to rd=0 -> wb_valid pulses, dbg r0 stays 0; instr_valid held high continuously -> accepts exactly every 4 cycles.
REQ-043 Assert rst in EXEC of an add to r6 -> no wb_valid, r6=0, instr_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/exec_ctrl.sv
// Serial four-state instruction sequencer driving an external 16-bit ALU.
// Holds an 8x16 register file (r0 reads zero) with a combinational debug read port.
module exec_ctrl #(
  parameter int DW  = 16,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [15:0]    instr,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [2:0]     alu_aluc,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_z,
  output logic           wb_valid,
  output logic [RAW-1:0] wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic           cmp_eq,
  input  logic [RAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;
  localparam logic [2:0] OP_NEG = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd7;
  localparam int NREG = 1 << RAW;

  logic [1:0]     state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [RAW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic           z_q, z_d;
  logic           wb_valid_q, wb_valid_d, cmp_eq_q, cmp_eq_d;
  logic [RAW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0]  wb_data_q, wb_data_d;
  logic [DW-1:0]  rf_q [NREG];
  logic [DW-1:0]  rf_d [NREG];
  logic           accept_s, exec_s, rf_we_s, unused_s;

  assign unused_s    = ^instr[3:0];
  assign instr_ready = (state_q == IDLE) && !rst;
  assign accept_s    = instr_valid && instr_ready;
  assign exec_s      = (state_q == EXEC);
  assign rf_we_s     = (state_q == WB) && (op_q != OP_CMP) && (rd_q != {RAW{1'b0}});

  // Operands reach the ALU only during EXEC; negate ignores its second operand.
  assign alu_a    = exec_s ? a_q : {DW{1'b0}};
  assign alu_b    = (exec_s && (op_q != OP_NEG)) ? b_q : {DW{1'b0}};
  assign alu_aluc = exec_s ? op_q : 3'd0;
  assign dbg_data = rf_q[dbg_addr];
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign cmp_eq   = cmp_eq_q;

  // Next-state, instruction/operand/result latches and write-back strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? FETCH : IDLE;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept_s) begin
      op_d = instr[15:13];
      rd_d = instr[12:10];
      rs_d = instr[9:7];
      rt_d = instr[6:4];
    end else begin
      op_d = op_q;
      rd_d = rd_q;
      rs_d = rs_q;
      rt_d = rt_q;
    end

    if (state_q == FETCH) begin
      a_d = rf_q[rs_q];
      b_d = rf_q[rt_q];
    end else begin
      a_d = a_q;
      b_d = b_q;
    end

    if (exec_s) begin
      y_d = alu_y;
      z_d = alu_z;
    end else begin
      y_d = y_q;
      z_d = z_q;
    end

    // Strobes are registered on the EXEC->WB edge so they are visible for the WB cycle only.
    wb_valid_d = exec_s && (op_q != OP_CMP);
    wb_addr_d  = wb_valid_d ? rd_q : {RAW{1'b0}};
    wb_data_d  = wb_valid_d ? alu_y : {DW{1'b0}};
    cmp_eq_d   = exec_s && (op_q == OP_CMP) && alu_z;

    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = (rf_we_s && (rd_q == RAW'(i))) ? y_q : rf_q[i];
    end
  end

  // State update with synchronous reset clearing the whole datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      rd_q       <= {RAW{1'b0}};
      rs_q       <= {RAW{1'b0}};
      rt_q       <= {RAW{1'b0}};
      a_q        <= {DW{1'b0}};
      b_q        <= {DW{1'b0}};
      y_q        <= {DW{1'b0}};
      z_q        <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= {RAW{1'b0}};
      wb_data_q  <= {DW{1'b0}};
      cmp_eq_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      y_q        <= y_d;
      z_q        <= z_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cmp_eq_q   <= cmp_eq_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule
